// File: rtl/sid_pattern_seq.sv
// Programmable drum step sequencer that drives one SID voice register set directly.
// Pattern RAM holds a 3-bit code per step: [2] accent, [1:0] rest/kick/snare/hi-hat.
module sid_pattern_seq #(
    parameter int N_STEPS = 16,
    parameter int STEP_W  = $clog2(N_STEPS),
    parameter int DIV_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DIV_W-1:0]  step_period,
    input  logic [DIV_W-1:0]  gate_len,
    input  logic              pat_we,
    input  logic [STEP_W-1:0] pat_addr,
    input  logic [2:0]        pat_wdata,
    output logic [15:0]       frequency,
    output logic [7:0]        duration,
    output logic [7:0]        attack,
    output logic [7:0]        sustain,
    output logic [7:0]        waveform,
    output logic [STEP_W-1:0] step_idx,
    output logic              step_strobe
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t              state;
    logic [2:0]          ram [N_STEPS];
    logic [2:0]          cur_code;
    logic [DIV_W-1:0]    tcnt;
    logic [DIV_W-1:0]    gcnt;

    logic [DIV_W-1:0]    p_eff;
    logic [DIV_W-1:0]    g_eff;
    logic [DIV_W-1:0]    gcnt_dec;
    logic                boundary;
    logic [STEP_W-1:0]   idx_next;
    logic [2:0]          code_next;

    // Boom-bap groove K.H.S.H.K..KHS.H, repeated every 16 steps, no accents.
    function automatic logic [2:0] default_code(input int i);
        logic [3:0] k;
        k = 4'(i);
        case (k)
            4'd0, 4'd8, 4'd11:         default_code = 3'd1;
            4'd4, 4'd13:               default_code = 3'd2;
            4'd2, 4'd6, 4'd12, 4'd15:  default_code = 3'd3;
            default:                   default_code = 3'd0;
        endcase
    endfunction

    // Returns {frequency, duration, attack, sustain, waveform}.
    function automatic logic [47:0] voice(input logic [2:0] code, input logic gate);
        logic [15:0] f;
        logic [7:0]  d;
        logic [7:0]  a;
        logic [7:0]  s;
        logic [7:0]  w;
        f = '0;
        d = '0;
        a = '0;
        s = '0;
        w = '0;
        case (code[1:0])
            2'd1: begin f = 16'h0020; d = 8'h80; a = 8'h40; s = 8'h00; w = 8'h10; end
            2'd2: begin f = 16'h0800; d = 8'h80; a = 8'h20; s = 8'h08; w = 8'h80; end
            2'd3: begin f = 16'h1000; d = 8'h80; a = 8'h10; s = 8'h00; w = 8'h80; end
            default: ;
        endcase
        if (code[2] && code[1:0] != 2'd0) s[7:4] = 4'hF;
        w[0] = gate;
        voice = {f, d, a, s, w};
    endfunction

    always_comb begin
        p_eff     = (step_period == '0) ? DIV_W'(1) : step_period;
        g_eff     = (gate_len < p_eff) ? gate_len : p_eff;
        gcnt_dec  = (gcnt != '0) ? gcnt - DIV_W'(1) : '0;
        boundary  = (state == IDLE) || (tcnt == '0);
        idx_next  = (state == IDLE) ? '0 : step_idx + STEP_W'(1);
        code_next = ram[idx_next];
    end

    // Gate length is clamped to the period, so each step ends with at least one
    // gate-low cycle and the envelope always retriggers on the next step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            cur_code    <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
            {frequency, duration, attack, sustain, waveform} <= '0;
            for (int i = 0; i < N_STEPS; i++) ram[i] <= default_code(i);
        end else begin
            if (pat_we) ram[pat_addr] <= pat_wdata;

            if (!run) begin
                state       <= IDLE;
                step_idx    <= '0;
                step_strobe <= 1'b0;
                cur_code    <= '0;
                tcnt        <= '0;
                gcnt        <= '0;
                {frequency, duration, attack, sustain, waveform} <= '0;
            end else if (boundary) begin
                state       <= PLAY;
                step_idx    <= idx_next;
                step_strobe <= 1'b1;
                cur_code    <= code_next;
                tcnt        <= p_eff;
                gcnt        <= g_eff;
                {frequency, duration, attack, sustain, waveform} <=
                    voice(code_next, (g_eff != '0) && (code_next[1:0] != 2'd0));
            end else begin
                step_strobe <= 1'b0;
                tcnt        <= tcnt - DIV_W'(1);
                gcnt        <= gcnt_dec;
                {frequency, duration, attack, sustain, waveform} <=
                    voice(cur_code, (gcnt_dec != '0) && (cur_code[1:0] != 2'd0));
            end
        end
    end

endmodule
